// File: rtl/fc_stream_wrapper_if.sv
// Streaming handshake bundle for fc_stream_wrapper.
//   s_valid/s_ready/s_data/s_last : activation beats into the wrapper
//   m_valid/m_ready/m_data        : registered layer result out of the wrapper
// Modports:
//   slave  - the wrapper's view (consumes s_*, produces m_*)
//   master - the environment's view (produces s_*, consumes m_*)
interface fc_stream_wrapper_if #(
   parameter int WIDTH = 8,
   parameter int ZW    = 23
);
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [ZW-1:0]    m_data;

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data
   );
endinterface

// File: rtl/fc_stream_wrapper.sv
// Collects one frame of IN activations from a valid/ready stream into a
// buffer, presents the frame on x_vec to a combinational layer, registers
// the layer result z_in and offers it downstream with valid/ready.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fc_stream_wrapper_if.slave (s_* input stream, m_* result)
//   x_vec      : buffered frame, element k at [k*WIDTH +: WIDTH]
//   z_in       : layer result computed from x_vec
//   err_len    : one-cycle pulse when a frame is dropped for wrong length
//
// state  | meaning
// FILL   | accepting beats into buffer[cnt]; s_ready high
// SETTLE | frame complete, one cycle for the layer to settle on x_vec
// OUT    | result held on m_data/m_valid until downstream takes it
module fc_stream_wrapper #(
   parameter int WIDTH = 8,
   parameter int IN    = 128,
   parameter int ZW    = 23
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fc_stream_wrapper_if.slave    bus,
   output logic [IN*WIDTH-1:0]   x_vec,
   input  logic [ZW-1:0]         z_in,
   output logic                  err_len
);

   localparam int CW = (IN > 1) ? $clog2(IN) : 1;

   typedef enum logic [1:0] {FILL, SETTLE, OUT} state_t;

   state_t            state;
   state_t            state_next;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  buffer [IN];
   logic              m_valid_q;
   logic [ZW-1:0]     m_data_q;

   logic beat;
   logic at_end;
   logic frame_ok;
   logic frame_bad;

   assign bus.s_ready = (state == FILL);
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;

   assign beat      = bus.s_valid && (state == FILL);
   assign at_end    = (cnt == CW'(IN - 1));
   assign frame_ok  = beat && bus.s_last && at_end;
   // s_last and the final slot must coincide; either one alone drops the frame
   assign frame_bad = beat && (bus.s_last != at_end);

   genvar g;
   for (g = 0; g < IN; g++) begin : g_xvec
      assign x_vec[g*WIDTH +: WIDTH] = buffer[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         FILL:    if (frame_ok) state_next = SETTLE;
         SETTLE:  state_next = OUT;
         OUT:     if (bus.m_ready) state_next = FILL;
         default: state_next = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         err_len   <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         for (int k = 0; k < IN; k++) begin
            buffer[k] <= '0;
         end
      end else begin
         err_len <= frame_bad;
         if (beat) begin
            buffer[cnt] <= bus.s_data;
            if (bus.s_last || at_end) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
         // x_vec has been stable for the whole SETTLE cycle, so z_in is final
         if (state == SETTLE) begin
            m_valid_q <= 1'b1;
            m_data_q  <= z_in;
         end else if (state == OUT && bus.m_ready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fc_stream_wrapper.sv
module tb_fc_stream_wrapper;

   localparam int WIDTH = 8;
   localparam int IN    = 128;
   localparam int ZW    = 23;

   logic                clk;
   logic                rst_n;
   logic [IN*WIDTH-1:0] x_vec;
   logic [ZW-1:0]       z_in;
   logic                err_len;

   fc_stream_wrapper_if #(.WIDTH(WIDTH), .ZW(ZW)) bus ();

   fc_stream_wrapper #(.WIDTH(WIDTH), .IN(IN), .ZW(ZW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .x_vec   (x_vec),
      .z_in    (z_in),
      .err_len (err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stand-in layer: weighted sum of the presented frame
   function automatic logic [ZW-1:0] layer_f(input logic [IN*WIDTH-1:0] v);
      int acc;
      acc = 0;
      for (int k = 0; k < IN; k++) begin
         acc += int'(v[k*WIDTH +: WIDTH]) * (k % 7 + 1);
      end
      return acc[ZW-1:0];
   endfunction

   always_comb z_in = layer_f(x_vec);

   typedef struct {
      string name;
      int    n;
      int    last_at;
      bit    gap;
      int    stall;
      int    seed;
      bit    exp_err;
   } vec_t;

   vec_t              tbl [9];
   logic [WIDTH-1:0]  mbuf [IN];
   logic [ZW-1:0]     exp_q [$];
   int                checks;
   int                failures;

   function automatic logic [WIDTH-1:0] dval(input int seed, input int i);
      int t;
      if (seed == 0) t = i;
      else t = (i * 37 + seed * 11) ^ (seed << 3);
      return t[WIDTH-1:0];
   endfunction

   function automatic logic [IN*WIDTH-1:0] model_vec();
      logic [IN*WIDTH-1:0] v;
      for (int k = 0; k < IN; k++) v[k*WIDTH +: WIDTH] = mbuf[k];
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name);
      logic [IN*WIDTH-1:0] e;
      e = model_vec();
      checks++;
      if (x_vec !== e) begin
         failures++;
         for (int k = 0; k < IN; k++) begin
            if (x_vec[k*WIDTH +: WIDTH] !== e[k*WIDTH +: WIDTH]) begin
               $display("FAIL %s x_vec[%0d] actual=%0h required=%0h", name, k,
                        x_vec[k*WIDTH +: WIDTH], e[k*WIDTH +: WIDTH]);
               break;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int k = 0; k < IN; k++) mbuf[k] = '0;
   endtask

   // drives n beats; checks no early error/result after every non-final beat
   task automatic send_beats(input int n, input int last_at, input int seed, input bit gap);
      for (int i = 0; i < n; i++) begin
         if (gap && i > 0) begin
            bus.s_valid = 1'b0;
            step();
            chk("gap_ready", bus.s_ready, 1);
         end
         bus.s_valid = 1'b1;
         bus.s_data  = dval(seed, i);
         bus.s_last  = (i == last_at);
         chk("fill_ready", bus.s_ready, 1);
         step();
         mbuf[i] = dval(seed, i);
         bus.s_valid = 1'b0;
         bus.s_last  = 1'b0;
         if (i < n - 1) begin
            chk("mid_err", err_len, 0);
            chk("mid_mvalid", bus.m_valid, 0);
         end
      end
   endtask

   task automatic run_vec(input vec_t t);
      logic [ZW-1:0] e;
      send_beats(t.n, t.last_at, t.seed, t.gap);
      if (!t.exp_err) begin
         exp_q.push_back(layer_f(model_vec()));
         chk({t.name, "_settle_err"}, err_len, 0);
         chk({t.name, "_settle_mvalid"}, bus.m_valid, 0);
         chk({t.name, "_settle_ready"}, bus.s_ready, 0);
         chk_vec({t.name, "_settle_xvec"});
         // junk beat and early m_ready must both be ignored in SETTLE
         bus.s_valid = 1'b1;
         bus.s_data  = 8'hA5;
         bus.s_last  = 1'b1;
         bus.m_ready = 1'b1;
         step();
         bus.m_ready = 1'b0;
         chk({t.name, "_out_mvalid"}, bus.m_valid, 1);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         chk({t.name, "_out_mdata"}, bus.m_data, e);
         chk({t.name, "_out_ready"}, bus.s_ready, 0);
         for (int s = 0; s < t.stall; s++) begin
            step();
            chk({t.name, "_stall_mvalid"}, bus.m_valid, 1);
            chk({t.name, "_stall_mdata"}, bus.m_data, e);
            chk({t.name, "_stall_ready"}, bus.s_ready, 0);
            chk_vec({t.name, "_stall_xvec"});
         end
         bus.m_ready = 1'b1;
         step();
         bus.m_ready = 1'b0;
         bus.s_valid = 1'b0;
         bus.s_last  = 1'b0;
         chk({t.name, "_hs_mvalid"}, bus.m_valid, 0);
         chk({t.name, "_hs_ready"}, bus.s_ready, 1);
         chk({t.name, "_hs_err"}, err_len, 0);
         chk_vec({t.name, "_hs_xvec"});
      end else begin
         chk({t.name, "_err_pulse"}, err_len, 1);
         chk({t.name, "_err_mvalid"}, bus.m_valid, 0);
         chk({t.name, "_err_ready"}, bus.s_ready, 1);
         chk_vec({t.name, "_err_xvec"});
         step();
         chk({t.name, "_err_one_cycle"}, err_len, 0);
         chk({t.name, "_err_mvalid2"}, bus.m_valid, 0);
         step();
         chk({t.name, "_err_mvalid3"}, bus.m_valid, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      logic [ZW-1:0] e;
      checks   = 0;
      failures = 0;
      tbl[0] = '{"ramp",      128, 127, 1'b0, 0,  0,  1'b0};
      tbl[1] = '{"ramp_gap",  128, 127, 1'b1, 0,  0,  1'b0};
      tbl[2] = '{"stall10",   128, 127, 1'b0, 10, 3,  1'b0};
      tbl[3] = '{"short50",   51,  50,  1'b0, 0,  5,  1'b0};
      tbl[4] = '{"after50",   128, 127, 1'b0, 2,  7,  1'b0};
      tbl[5] = '{"nolast",    128, -1,  1'b0, 0,  9,  1'b0};
      tbl[6] = '{"after_nl",  128, 127, 1'b1, 3,  11, 1'b0};
      tbl[7] = '{"first_last", 1,  0,   1'b0, 0,  15, 1'b0};
      tbl[8] = '{"after_fl",  128, 127, 1'b0, 1,  13, 1'b0};
      tbl[3].exp_err = 1'b1;
      tbl[5].exp_err = 1'b1;
      tbl[7].exp_err = 1'b1;

      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;
      rst_n       = 1'b0;
      clear_model();
      step();
      step();
      chk("rst_mvalid", bus.m_valid, 0);
      chk("rst_mdata", bus.m_data, 0);
      chk("rst_err", err_len, 0);
      chk("rst_ready", bus.s_ready, 1);
      chk_vec("rst_xvec");
      rst_n = 1'b1;

      for (int v = 0; v < 9; v++) run_vec(tbl[v]);

      // reset in the middle of a frame, then a clean frame
      send_beats(70, -1, 21, 1'b0);
      rst_n = 1'b0;
      #1;
      clear_model();
      chk("midrst_xvec_clear", (x_vec == '0), 1);
      chk("midrst_mvalid", bus.m_valid, 0);
      chk("midrst_err", err_len, 0);
      step();
      step();
      chk("midrst_hold_mvalid", bus.m_valid, 0);
      rst_n = 1'b1;
      run_vec('{"post_rst", 128, 127, 1'b0, 0, 23, 1'b0});

      // reset while the result is being held
      send_beats(128, 127, 19, 1'b0);
      exp_q.push_back(layer_f(model_vec()));
      step();
      chk("outrst_mvalid", bus.m_valid, 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("outrst_mdata", bus.m_data, e);
      rst_n = 1'b0;
      #1;
      clear_model();
      chk("outrst_mvalid_clr", bus.m_valid, 0);
      chk("outrst_mdata_clr", bus.m_data, 0);
      chk_vec("outrst_xvec");
      step();
      rst_n = 1'b1;
      step();
      chk("outrst_after_mvalid", bus.m_valid, 0);
      chk("outrst_after_ready", bus.s_ready, 1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
